// File: rtl/fifo_reader.sv
// fifo_reader: pops a show-ahead FIFO into a registered valid/ready stream with packet framing, run enable and flush.
// Latency: a word popped at edge N is valid in cycle N+1; a 2-entry buffer sustains 1 word/cycle.
// Backpressure: out_ready only frees buffer slots; pops stop with 2 words held. FIFO_READER_STATS_EN adds counters.
module fifo_reader #(
  parameter int WIDTH   = 16,
  parameter int PKT_LEN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_read,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [31:0]      stat_words,
  output logic [31:0]      stat_dropped
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             last;
  } entry_t;

  localparam logic [15:0] LAST_TAG = 16'(PKT_LEN - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  entry_t      head_q, tail_q;
  logic [15:0] pkt_q;
  logic [15:0] pkt_nxt;
  entry_t      new_entry;
  logic        pop, pop_run, xfer, flush_enter;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_read = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush)   state_d = FLUSH;
        else if (en) state_d = RUN;
      end
      RUN: begin
        if (flush)    state_d = FLUSH;
        else if (!en) state_d = IDLE;
      end
      FLUSH: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fifo_read = ((state_q == RUN) && (cnt_q < 2'd2)) || (state_q == FLUSH);
    out_valid = (cnt_q != 2'd0) && (state_q != FLUSH);
    busy      = (state_q != IDLE) || (cnt_q != 2'd0);
  end

  assign pop         = fifo_read && !fifo_empty;
  assign pop_run     = pop && (state_q == RUN);
  assign xfer        = out_valid && out_ready;
  assign flush_enter = (state_q != FLUSH) && (state_d == FLUSH);

  // Every word popped in RUN is delivered in order unless a flush intervenes,
  // so the packet position can be tagged at pop time.
  assign pkt_nxt   = (pkt_q == LAST_TAG) ? 16'd0 : pkt_q + 16'd1;
  assign new_entry = '{dat: fifo_dout, last: (pkt_q == LAST_TAG)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      pkt_q  <= 16'd0;
    end else if (flush_enter) begin
      cnt_q <= 2'd0;
      pkt_q <= 16'd0;
    end else begin
      if (pop_run) pkt_q <= pkt_nxt;
      unique case ({xfer, pop_run})
        2'b10: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) head_q <= new_entry;
          else               tail_q <= new_entry;
          cnt_q <= cnt_q + 2'd1;
        end
        // Simultaneous pop and transfer only happens with one word held.
        2'b11: head_q <= new_entry;
        default: ;
      endcase
    end
  end

  assign out_data = head_q.dat;
  assign out_last = head_q.last;

`ifdef FIFO_READER_STATS_EN
  logic        pop_drop;
  logic [1:0]  drop_inc;
  logic [31:0] words_q, drop_q;
  logic [32:0] drop_sum;

  assign pop_drop = pop && (state_q == FLUSH);

  // On flush entry the lost words are those that would sit in the buffer after this edge.
  always_comb begin
    drop_inc = 2'd0;
    if (flush_enter)   drop_inc = cnt_q - {1'b0, xfer} + {1'b0, pop_run};
    else if (pop_drop) drop_inc = 2'd1;
  end

  assign drop_sum = {1'b0, drop_q} + {31'd0, drop_inc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      words_q <= 32'd0;
      drop_q  <= 32'd0;
    end else begin
      if (xfer && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
      drop_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

  assign stat_words   = words_q;
  assign stat_dropped = drop_q;
`else
  assign stat_words   = 32'd0;
  assign stat_dropped = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO, transaction-level reference model, directed scenarios then random traffic.
module tb_fifo_reader;
  localparam int WIDTH   = 16;
  localparam int PKT_LEN = 8;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FLUSH = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_read;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [31:0]      stat_words;
  logic [31:0]      stat_dropped;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fifo_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(fifo_read), .en(en), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .stat_words(stat_words), .stat_dropped(stat_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Show-ahead FIFO: pushes queued by stimulus land at the next edge; empty/dout are registered.
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] push_q[$];
  int pop_cnt = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      push_q.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_read && !fifo_empty) begin
        void'(fq.pop_front());
        pop_cnt++;
      end
      while (push_q.size() > 0) fq.push_back(push_q.pop_front());
      fifo_empty <= (fq.size() == 0);
      fifo_dout  <= (fq.size() != 0) ? fq[0] : '0;
    end
  end

  // Reference model: state, queue of words awaiting delivery, delivered-since-flush count.
  int               ms = S_IDLE;
  logic [WIDTH-1:0] mbuf[$];
  int               mpos = 0;
  longint           mwords = 0;
  longint           mdrop = 0;
  int               cyc = 0;
  int               xfer_cyc[$];
  bit               xfer_last[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ms = S_IDLE;
      mbuf.delete();
      mpos = 0;
      mwords = 0;
      mdrop = 0;
    end else begin
      bit fr, pop, ov, xf;
      int nx;
      fr  = (ms == S_RUN && mbuf.size() < 2) || ms == S_FLUSH;
      pop = fr && !fifo_empty;
      ov  = (mbuf.size() != 0) && ms != S_FLUSH;
      xf  = ov && out_ready;
      nx  = ms;
      if (ms == S_FLUSH) begin
        if (fifo_empty) nx = S_IDLE;
      end else if (flush) nx = S_FLUSH;
      else nx = en ? S_RUN : S_IDLE;
      if (xf) begin
        void'(mbuf.pop_front());
        mpos++;
        mwords++;
      end
      if (pop && ms == S_RUN) mbuf.push_back(fifo_dout);
      if (pop && ms == S_FLUSH) mdrop++;
      if (nx == S_FLUSH && ms != S_FLUSH) begin
        mdrop += mbuf.size();
        mbuf.delete();
        mpos = 0;
      end
      ms = nx;
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        xfer_last.push_back(out_last);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stats", stat_words | stat_dropped, 32'd0);
    end else begin
      bit efr, eov, ebusy;
      efr   = (ms == S_RUN && mbuf.size() < 2) || ms == S_FLUSH;
      eov   = (mbuf.size() != 0) && ms != S_FLUSH;
      ebusy = ms != S_IDLE || mbuf.size() != 0;
      chk("fifo_read", 32'(fifo_read), 32'(efr));
      chk("out_valid", 32'(out_valid), 32'(eov));
      chk("busy", 32'(busy), 32'(ebusy));
      if (eov) begin
        chk("out_data", 32'(out_data), 32'(mbuf[0]));
        chk("out_last", 32'(out_last), 32'((mpos % PKT_LEN) == PKT_LEN - 1));
      end
`ifdef FIFO_READER_STATS_EN
      chk("stat_words", stat_words, (mwords > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(mwords));
      chk("stat_dropped", stat_dropped, (mdrop > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(mdrop));
`else
      chk("stat_words", stat_words, 32'd0);
      chk("stat_dropped", stat_dropped, 32'd0);
`endif
    end
  end

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) push_q.push_back(WIDTH'(first + i));
  endtask

  initial begin
    int pc0, k, span, nlast;

    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // 16 preloaded words stream back to back, framed every 8.
    push_words(1, 16);
    @(negedge clk);
    xfer_cyc.delete();
    xfer_last.delete();
    en = 1'b1;
    out_ready = 1'b1;
    repeat (22) @(negedge clk);
    span = (xfer_cyc.size() >= 16) ? xfer_cyc[15] - xfer_cyc[0] : -1;
    nlast = 0;
    foreach (xfer_last[i]) nlast += int'(xfer_last[i]);
    chk("s1_xfers", 32'(xfer_cyc.size()), 32'd16);
    chk("s1_consecutive", 32'(span), 32'd15);
    chk("s1_lasts", 32'(nlast), 32'd2);

    // Stalled output: only two pops, head word held.
    out_ready = 1'b0;
    pc0 = pop_cnt;
    push_words(1, 5);
    repeat (10) @(negedge clk);
    chk("bp_pops", 32'(pop_cnt - pc0), 32'd2);
    chk("bp_head", 32'(out_data), 32'h0001);
    chk("bp_busy", 32'(busy), 32'd1);
    xfer_cyc.delete();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    span = (xfer_cyc.size() >= 5) ? xfer_cyc[4] - xfer_cyc[0] : -1;
    chk("bp_xfers", 32'(xfer_cyc.size()), 32'd5);
    chk("bp_consecutive", 32'(span), 32'd4);

    // Disable with a full buffer: buffered words drain, no further pops.
    out_ready = 1'b0;
    push_words(16'h21, 3);
    repeat (4) @(negedge clk);
    en = 1'b0;
    pc0 = pop_cnt;
    repeat (4) @(negedge clk);
    chk("dis_pops", 32'(pop_cnt - pc0), 32'd0);
    xfer_cyc.delete();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("dis_xfers", 32'(xfer_cyc.size()), 32'd2);
    chk("dis_busy", 32'(busy), 32'd0);

    // Reset in the middle of a stream.
    en = 1'b1;
    out_ready = 1'b0;
    push_words(16'h51, 3);
    repeat (3) @(negedge clk);
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_fifo_read", 32'(fifo_read), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_stats", stat_words | stat_dropped, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Flush after 3 of 6 words: 2 buffered and 1 in the FIFO are dropped.
    push_words(16'h31, 6);
    k = 0;
    do begin @(negedge clk); k++; end while (mbuf.size() != 2 && k < 10);
    chk("fl_fill", 32'(mbuf.size()), 32'd2);
    xfer_cyc.delete();
    out_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (xfer_cyc.size() < 3 && k < 10);
    out_ready = 1'b0;
    chk("fl_xfers", 32'(xfer_cyc.size()), 32'd3);
    k = 0;
    do begin @(negedge clk); k++; end while (mbuf.size() != 2 && k < 10);
    chk("fl_refill", 32'(mbuf.size()), 32'd2);
    flush = 1'b1;
    en = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      flush = 1'b0;
      k++;
    end while (busy && k < 8);
    chk("fl_exit_fast", 32'(k <= 3), 32'd1);
    chk("fl_fifo_drained", 32'(fq.size()), 32'd0);
`ifdef FIFO_READER_STATS_EN
    chk("fl_stat_words", stat_words, 32'd3);
    chk("fl_stat_dropped", stat_dropped, 32'd3);
`endif
    push_words(16'h41, 8);
    xfer_cyc.delete();
    xfer_last.delete();
    en = 1'b1;
    out_ready = 1'b1;
    repeat (14) @(negedge clk);
    nlast = 0;
    foreach (xfer_last[i]) nlast += int'(xfer_last[i]);
    chk("fl_next_xfers", 32'(xfer_last.size()), 32'd8);
    chk("fl_next_last8", 32'((xfer_last.size() == 8) && xfer_last[7]), 32'd1);
    chk("fl_next_lastcnt", 32'(nlast), 32'd1);

    // Flush and enable together from IDLE: words are discarded, never delivered.
    en = 1'b0;
    repeat (2) @(negedge clk);
    push_words(16'h61, 2);
    repeat (2) @(negedge clk);
    xfer_cyc.delete();
    en = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    en = 1'b0;
    flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("fe_no_xfer", 32'(xfer_cyc.size()), 32'd0);
    chk("fe_fifo_drained", 32'(fq.size()), 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en        = ($urandom % 8) != 0;
      flush     = ($urandom % 40) == 0;
      out_ready = ($urandom % 3) != 0;
      if (($urandom % 2) == 1 && (fq.size() + push_q.size()) < 12)
        push_q.push_back(WIDTH'($urandom));
    end
    flush = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
